// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link: receiver state encoding and default slot count.
package tdm_pkg;

   localparam int TDM_NUM_CH = 8;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } tdm_state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: clear on lock loss, restart at 1 on sync, otherwise advance on enable.
module tdm_slot_counter #(
   parameter int SEL_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load1,
   input  logic             clr,
   output logic [SEL_W-1:0] cnt,
   output logic             tc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load1) begin
         cnt <= SEL_W'(1);
      end else if (en) begin
         cnt <= cnt + SEL_W'(1);
      end
   end

   // Slot count is a power of two, so the last slot is all ones.
   assign tc = &cnt;

endmodule

// File: rtl/tdm_demux_8ch.sv
// Receive end of an 8-slot TDM link: locks to frame sync and deserialises each frame into ch_out.
// state  | meaning
// HUNT   | unaligned; waiting for a valid bit carrying sync
// LOCKED | aligned; slot is the index expected for the next valid bit
module tdm_demux_8ch
   import tdm_pkg::*;
#(
   parameter int NUM_CH = TDM_NUM_CH,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              din,
   input  logic              din_valid,
   input  logic              sync,
   output logic [NUM_CH-1:0] ch_out,
   output logic              frame_valid,
   output logic [SEL_W-1:0]  slot,
   output logic              locked,
   output logic              sync_err
);

   tdm_state_t        state;
   logic [NUM_CH-1:0] asm_q;
   logic [NUM_CH-1:0] asm_next;
   logic [SEL_W-1:0]  wr_idx;
   logic              is_locked;
   logic              tc;
   logic              cnt_en;
   logic              cnt_load;
   logic              cnt_clr;
   logic              store;
   logic              err;
   logic              frame_done;

   assign is_locked  = (state == LOCKED);
   assign cnt_load   = din_valid & sync;
   assign cnt_clr    = din_valid & is_locked & ~sync & (slot == '0);
   assign cnt_en     = din_valid & is_locked & ~sync & (slot != '0);
   assign store      = cnt_load | cnt_en;
   // Violation: sync missing where slot 0 is due, or sync arriving mid-frame.
   assign err        = din_valid & is_locked & (sync ^ (slot == '0));
   assign frame_done = cnt_en & tc;
   assign wr_idx     = sync ? '0 : slot;
   assign locked     = is_locked;

   always_comb begin
      asm_next         = asm_q;
      asm_next[wr_idx] = din;
   end

   tdm_slot_counter #(
      .SEL_W (SEL_W)
   ) u_slot_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (cnt_en),
      .load1 (cnt_load),
      .clr   (cnt_clr),
      .cnt   (slot),
      .tc    (tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= HUNT;
         asm_q       <= '0;
         ch_out      <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         frame_valid <= frame_done;
         sync_err    <= err;
         if (store) begin
            asm_q <= asm_next;
         end
         if (frame_done) begin
            ch_out <= asm_next;
         end
         if (din_valid) begin
            if (sync) begin
               state <= LOCKED;
            end else if (cnt_clr) begin
               state <= HUNT;
            end
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux_8ch.sv
// Bench for tdm_demux_8ch: expected frames queued at drive time, compared when frame_valid pulses.
module tb_tdm_demux_8ch;

   logic       clk;
   logic       rst_n;
   logic       din;
   logic       din_valid;
   logic       sync;
   logic [7:0] ch_out;
   logic       frame_valid;
   logic [2:0] slot;
   logic       locked;
   logic       sync_err;

   int         n_chk;
   int         n_fail;
   int         cyc;
   int         err_cnt;
   logic [7:0] exp_q[$];
   int         fv_hist[$];

   tdm_demux_8ch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .din_valid   (din_valid),
      .sync        (sync),
      .ch_out      (ch_out),
      .frame_valid (frame_valid),
      .slot        (slot),
      .locked      (locked),
      .sync_err    (sync_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every frame_valid must match the oldest queued frame.
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_valid) begin
            fv_hist.push_back(cyc);
            if (exp_q.size() == 0) check("fv_unexpected", {31'd0, frame_valid}, 32'd0);
            else check("frame", {24'd0, ch_out}, {24'd0, exp_q.pop_front()});
         end
         if (sync_err) err_cnt++;
      end
   end

   task automatic drive(input logic v, input logic s, input logic d);
      din_valid = v;
      sync      = s;
      din       = d;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] data, input bit gaps);
      exp_q.push_back(data);
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, k == 0, data[k]);
         if (gaps) begin
            drive(1'b0, 1'b0, 1'b0);
            check("gap_slot", {29'd0, slot}, (k + 1) % 8);
         end
      end
   endtask

   initial begin
      n_chk = 0; n_fail = 0; cyc = 0; err_cnt = 0;
      din = 0; din_valid = 0; sync = 0;
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ch_out", {24'd0, ch_out}, 0);
      check("rst_fv", {31'd0, frame_valid}, 0);
      check("rst_slot", {29'd0, slot}, 0);
      check("rst_locked", {31'd0, locked}, 0);
      check("rst_sync_err", {31'd0, sync_err}, 0);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;

      // Unsynced bits in HUNT are discarded silently
      drive(1'b1, 1'b0, 1'b1);
      check("hunt_locked", {31'd0, locked}, 0);
      check("hunt_err", {31'd0, sync_err}, 0);

      // Single frame 1,1,0,0,1,0,1,1
      send_frame(8'hD3, 1'b0);
      check("d3_fv", {31'd0, frame_valid}, 1);
      check("d3_ch_out", {24'd0, ch_out}, 8'hD3);
      check("d3_locked", {31'd0, locked}, 1);
      drive(1'b0, 1'b0, 1'b0);
      check("d3_fv_one_cycle", {31'd0, frame_valid}, 0);

      // Back-to-back frames
      send_frame(8'hD3, 1'b0);
      send_frame(8'h5A, 1'b0);
      check("b2b_ch_out", {24'd0, ch_out}, 8'h5A);
      drive(1'b0, 1'b0, 1'b0);
      check("b2b_spacing", fv_hist[fv_hist.size()-1] - fv_hist[fv_hist.size()-2], 8);

      // din_valid gaps do not advance slot
      send_frame(8'hA5, 1'b1);
      check("gap_ch_out", {24'd0, ch_out}, 8'hA5);
      check("gap_fv_clear", {31'd0, frame_valid}, 0);

      // Early sync at slot 4: partial frame dropped, new frame 8'h3C starts
      for (int k = 0; k < 4; k++) drive(1'b1, k == 0, 1'b1);
      exp_q.push_back(8'h3C);
      drive(1'b1, 1'b1, 1'b0);
      check("early_err", {31'd0, sync_err}, 1);
      check("early_slot", {29'd0, slot}, 1);
      check("early_locked", {31'd0, locked}, 1);
      check("early_no_fv", {31'd0, frame_valid}, 0);
      for (int k = 1; k < 8; k++) drive(1'b1, 1'b0, k >= 2 && k <= 5);
      check("early_ch_out", {24'd0, ch_out}, 8'h3C);

      // Missing sync at slot 0 drops lock
      drive(1'b1, 1'b0, 1'b1);
      check("miss_err", {31'd0, sync_err}, 1);
      check("miss_locked", {31'd0, locked}, 0);
      check("miss_slot", {29'd0, slot}, 0);
      check("miss_ch_out", {24'd0, ch_out}, 8'h3C);
      drive(1'b0, 1'b0, 1'b0);
      check("miss_err_pulse", {31'd0, sync_err}, 0);
      send_frame(8'h81, 1'b0);
      check("relock_ch_out", {24'd0, ch_out}, 8'h81);
      check("relock_locked", {31'd0, locked}, 1);

      // Asynchronous reset at slot 5
      for (int k = 0; k < 5; k++) drive(1'b1, k == 0, 1'b1);
      check("pre_rst_slot", {29'd0, slot}, 5);
      #2;
      rst_n = 0;
      #1;
      check("arst_ch_out", {24'd0, ch_out}, 0);
      check("arst_slot", {29'd0, slot}, 0);
      check("arst_locked", {31'd0, locked}, 0);
      check("arst_fv", {31'd0, frame_valid}, 0);
      @(posedge clk);
      #2;
      rst_n = 1;
      for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 1'b1);
      check("post_rst_locked", {31'd0, locked}, 0);
      check("post_rst_ch_out", {24'd0, ch_out}, 0);
      drive(1'b0, 1'b0, 1'b0);

      check("sync_err_total", err_cnt, 2);
      check("frames_total", fv_hist.size(), 6);
      check("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
